// File: rtl/loader_write_bridge_if.sv
// Loader-side write strobe and SDRAM port-A write bus for loader_write_bridge.
// The slave modport is the bridge; the master modport is the loader/memory environment.
interface loader_write_bridge_if #(
    parameter int ADDR_W = 22
);
    logic              in_wr;
    logic [ADDR_W-1:0] in_addr;
    logic [7:0]        in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport slave (
        input  in_wr, in_addr, in_data,
        output mem_we, mem_addr, mem_data
    );

    modport master (
        output in_wr, in_addr, in_data,
        input  mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/loader_write_bridge.sv
// FIFO-buffered bridge from the ROM loader to SDRAM port A: one write per nes_ce slot.
// Optional write statistics (wr_total) are built only when LOADER_BRIDGE_STATS_EN is defined.
module loader_write_bridge #(
    parameter int         ADDR_W     = 22,
    parameter int         DEPTH_LOG2 = 2,
    parameter logic [1:0] SLOT_PHASE = 2'd1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            nes_ce,
    input  logic                  downloading,
    loader_write_bridge_if.slave  bus,
    output logic                  busy,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   count,
    output logic [ADDR_W-1:0]     wr_total
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int EW    = ADDR_W + 8;

    logic [EW-1:0]         fifo_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [7:0]            mem_data_q, mem_data_d;
    logic                  overflow_q, overflow_d;
    logic                  dl_q;

    logic slot, pop, full, push, drop, dl_rise;

    always_comb begin
        slot    = (nes_ce == SLOT_PHASE);
        pop     = slot && (count_q != '0);
        full    = (count_q == CW'(DEPTH));
        // A pop in the same clk frees the head slot, so a full FIFO still accepts.
        push    = bus.in_wr && (!full || pop);
        drop    = bus.in_wr && !push;
        dl_rise = downloading && !dl_q;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        overflow_d = overflow_q;

        if (push)
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);

        if (pop) begin
            rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(1);
            mem_addr_d = fifo_mem[rd_ptr_q][EW-1:8];
            mem_data_d = fifo_mem[rd_ptr_q][7:0];
        end

        // mem_we only changes on the slot clk, so each write is held a full nes_ce period.
        if (slot)
            mem_we_d = pop;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (dl_rise)
            overflow_d = 1'b0;
        if (drop)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= {bus.in_addr, bus.in_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            overflow_q <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            overflow_q <= overflow_d;
            dl_q       <= downloading;
        end
    end

`ifdef LOADER_BRIDGE_STATS_EN
    logic [ADDR_W-1:0] wr_total_q, wr_total_d;

    always_comb begin
        wr_total_d = wr_total_q;
        if (dl_rise)
            wr_total_d = '0;
        else if (pop)
            wr_total_d = wr_total_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wr_total_q <= '0;
        else
            wr_total_q <= wr_total_d;
    end

    assign wr_total = wr_total_q;
`else
    assign wr_total = '0;
`endif

    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign busy         = (count_q != '0) || mem_we_q;

endmodule

// File: tb/tb_loader_write_bridge.sv
// Directed bench for loader_write_bridge: per-clk vector table plus hand-written
// sequences for overflow, reset mid-burst and the write-statistics counter.
module tb_loader_write_bridge;
    localparam int AW = 22;
`ifdef LOADER_BRIDGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    nes_ce;
    logic          downloading;
    logic          busy, overflow;
    logic [2:0]    count;
    logic [AW-1:0] wr_total;

    loader_write_bridge_if #(.ADDR_W(AW)) bus ();

    loader_write_bridge #(
        .ADDR_W(AW), .DEPTH_LOG2(2), .SLOT_PHASE(2'd1)
    ) dut (
        .clk(clk), .reset(rst), .nes_ce(nes_ce), .downloading(downloading),
        .bus(bus), .busy(busy), .overflow(overflow), .count(count), .wr_total(wr_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    ce;
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          we;
        logic [AW-1:0] ea;
        logic [7:0]    ed;
        logic [2:0]    cnt;
        logic          bsy;
    } vec_t;

    vec_t              vecs[$];
    logic [AW+7:0]     seen[$];
    int                n_vec = 0;
    int                n_err = 0;
    logic [1:0]        fill_ce = 2'd0;
    logic [1:0]        ce_run  = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [AW-1:0] a, input logic [7:0] d,
                       input logic we, input logic [AW-1:0] ea, input logic [7:0] ed,
                       input logic [2:0] c, input logic b);
        vec_t v;
        v.ce = fill_ce; v.wr = wr; v.addr = a; v.data = d;
        v.we = we; v.ea = ea; v.ed = ed; v.cnt = c; v.bsy = b;
        fill_ce = fill_ce + 2'd1;
        vecs.push_back(v);
    endtask

    // Repeat the previous expectation for idle, non-slot clks.
    task automatic hold(input int n);
        for (int k = 0; k < n; k++) begin
            vec_t v;
            v = vecs[$];
            v.ce = fill_ce; v.wr = 1'b0;
            fill_ce = fill_ce + 2'd1;
            vecs.push_back(v);
        end
    endtask

    task automatic step(input logic wr, input logic [AW-1:0] a, input logic [7:0] d,
                        input logic [1:0] ce);
        bus.in_wr = wr; bus.in_addr = a; bus.in_data = d; nes_ce = ce;
        @(posedge clk);
        #1;
        if (ce == 2'd1 && bus.mem_we)
            seen.push_back({bus.mem_addr, bus.mem_data});
        bus.in_wr = 1'b0;
    endtask

    task automatic run(input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
        step(wr, a, d, ce_run);
        ce_run = ce_run + 2'd1;
    endtask

    initial begin
        rst = 1'b1; downloading = 1'b1; nes_ce = 2'd0;
        bus.in_wr = 1'b0; bus.in_addr = '0; bus.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.mem_we",   32'(bus.mem_we),   32'd0);
        chk("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst.mem_data", 32'(bus.mem_data), 32'd0);
        chk("rst.count",    32'(count),        32'd0);
        chk("rst.overflow", 32'(overflow),     32'd0);
        chk("rst.busy",     32'(busy),         32'd0);
        chk("rst.wr_total", 32'(wr_total),     32'd0);
        rst = 1'b0;

        // single byte, then a 4-byte burst, then a push on the slot clk itself
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 'h10, 'hA5, 0, 0, 0, 1, 1);
        hold(2);
        add(0, 0, 0, 1, 'h10, 'hA5, 0, 1);
        hold(3);
        add(0, 0, 0, 0, 'h10, 'hA5, 0, 0);
        add(1, 'h0, 'h10, 0, 'h10, 'hA5, 1, 1);
        add(1, 'h1, 'h11, 0, 'h10, 'hA5, 2, 1);
        add(1, 'h2, 'h12, 0, 'h10, 'hA5, 3, 1);
        add(1, 'h3, 'h13, 1, 'h0, 'h10, 3, 1);
        hold(3);
        add(0, 0, 0, 1, 'h1, 'h11, 2, 1);
        hold(3);
        add(0, 0, 0, 1, 'h2, 'h12, 1, 1);
        hold(3);
        add(0, 0, 0, 1, 'h3, 'h13, 0, 1);
        hold(3);
        add(0, 0, 0, 0, 'h3, 'h13, 0, 0);
        hold(3);
        add(1, 'h3FFFFF, 'hFF, 0, 'h3, 'h13, 1, 1);
        hold(3);
        add(0, 0, 0, 1, 'h3FFFFF, 'hFF, 0, 1);
        hold(3);
        add(0, 0, 0, 0, 'h3FFFFF, 'hFF, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].ce);
            if ({bus.mem_we, bus.mem_addr, bus.mem_data, count, busy} !==
                {vecs[i].we, vecs[i].ea, vecs[i].ed, vecs[i].cnt, vecs[i].bsy}) begin
                n_err++;
                $display("FAIL vec%0d: got we=%0b addr=0x%0h data=0x%0h cnt=%0d busy=%0b expected we=%0b addr=0x%0h data=0x%0h cnt=%0d busy=%0b",
                         i, bus.mem_we, bus.mem_addr, bus.mem_data, count, busy,
                         vecs[i].we, vecs[i].ea, vecs[i].ed, vecs[i].cnt, vecs[i].bsy);
            end
            n_vec++;
        end
        chk("tbl.overflow", 32'(overflow), 32'd0);
        chk("tbl.wr_total", 32'(wr_total), STATS ? 32'd6 : 32'd0);

        // overflow: six pushes with nes_ce held off the slot phase
        for (int k = 0; k < 6; k++) begin
            step(1'b1, AW'('h20 + k), 8'('h50 + k), 2'd2);
            chk($sformatf("ovf.count%0d", k), 32'(count), (k < 4) ? 32'(k + 1) : 32'd4);
            chk($sformatf("ovf.flag%0d", k), 32'(overflow), (k >= 4) ? 32'd1 : 32'd0);
        end
        seen.delete();
        ce_run = 2'd3;
        repeat (20) run(0, 0, 0);
        chk("ovf.emitted", 32'(seen.size()), 32'd4);
        for (int k = 0; k < 4 && k < seen.size(); k++)
            chk($sformatf("ovf.order%0d", k), 32'(seen[k]), 32'({AW'('h20 + k), 8'('h50 + k)}));
        chk("ovf.busy", 32'(busy), 32'd0);
        chk("ovf.wr_total", 32'(wr_total), STATS ? 32'd10 : 32'd0);
        downloading = 1'b0;
        run(0, 0, 0); run(0, 0, 0);
        chk("ovf.sticky", 32'(overflow), 32'd1);
        downloading = 1'b1;
        run(0, 0, 0); run(0, 0, 0);
        chk("ovf.cleared", 32'(overflow), 32'd0);
        chk("ovf.wr_total_clr", 32'(wr_total), 32'd0);

        // reset during mem_we with entries pending, loader not in download mode
        downloading = 1'b0;
        for (int k = 0; k < 4 && ce_run != 2'd2; k++) run(0, 0, 0);
        run(1, 'h30, 'h60); run(1, 'h31, 'h61); run(1, 'h32, 'h62);
        run(0, 0, 0);
        chk("rmb.mem_we", 32'(bus.mem_we), 32'd1);
        chk("rmb.addr", 32'(bus.mem_addr), 32'h30);
        chk("rmb.count", 32'(count), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("rmb.async_we", 32'(bus.mem_we), 32'd0);
        chk("rmb.async_count", 32'(count), 32'd0);
        chk("rmb.async_addr", 32'(bus.mem_addr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen.delete();
        repeat (12) run(0, 0, 0);
        chk("rmb.no_writes", 32'(seen.size()), 32'd0);
        chk("rmb.busy", 32'(busy), 32'd0);

        // 300-byte download, one byte per slot period
        downloading = 1'b1;
        run(0, 0, 0);
        seen.delete();
        for (int i = 0; i < 300; i++) begin
            run(1, AW'(i), 8'(i));
            repeat (3) run(0, 0, 0);
        end
        repeat (12) run(0, 0, 0);
        chk("dl.emitted", 32'(seen.size()), 32'd300);
        if (seen.size() == 300) begin
            chk("dl.first", 32'(seen[0]),   32'({AW'(0), 8'h00}));
            chk("dl.last",  32'(seen[299]), 32'({AW'(299), 8'(299)}));
        end
        chk("dl.overflow", 32'(overflow), 32'd0);
        chk("dl.count", 32'(count), 32'd0);
        chk("dl.wr_total", 32'(wr_total), STATS ? 32'd300 : 32'd0);
        downloading = 1'b0;
        run(0, 0, 0); run(0, 0, 0);
        downloading = 1'b1;
        run(0, 0, 0); run(0, 0, 0);
        chk("dl.wr_total_clr", 32'(wr_total), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
